// File: rtl/control_smoother.sv
// Smooths six ADC control channels with a first-order IIR filter and clamps the
// harmonic count. Results are committed to the outputs only at a DAC sample boundary.
module control_smoother #(
  parameter int unsigned DIV_BIT         = 11,
  parameter int unsigned NO_OF_HARMONICS = 100,
  parameter int unsigned SMOOTH_SHIFT    = 3
) (
  input  logic               i_Clock,
  input  logic               i_Reset,
  input  logic               i_Data_Received,
  input  logic [15:0]        i_Data0,
  input  logic [15:0]        i_Data1,
  input  logic [15:0]        i_Data2,
  input  logic [15:0]        i_Data3,
  input  logic [15:0]        i_Data4,
  input  logic [15:0]        i_Data5,
  input  logic [15:0]        i_Data6,
  input  logic               i_Sample_Boundary,
  output logic [15:0]        o_Frequency,
  output logic [DIV_BIT-1:0] o_Harmonic_Scale0,
  output logic [DIV_BIT-1:0] o_Scale_Initial0,
  output logic [DIV_BIT-1:0] o_Harmonic_Scale1,
  output logic [DIV_BIT-1:0] o_Scale_Initial1,
  output logic [15:0]        o_Freq_Scale,
  output logic [7:0]         o_Harmonic_Count,
  output logic               o_Update,
  output logic               o_Busy
);

  localparam int unsigned DATA_W   = 16;
  localparam int unsigned HC_W     = 8;
  localparam int unsigned CH_W     = 3;
  localparam int unsigned N_SMOOTH = 6;
  localparam int unsigned N_CH     = 7;
  localparam logic [DATA_W-1:0] FREQ_RESET = DATA_W'(90);
  localparam logic [HC_W-1:0]   HC_MAX     = HC_W'(NO_OF_HARMONICS);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(N_CH - 1);

  typedef enum logic [2:0] {
    sm_idle,
    sm_capture,
    sm_filter,
    sm_wait_boundary,
    sm_commit
  } state_t;

  state_t state_q, state_d;

  logic              sync1_q, sync2_q, sync3_q, edge_q;
  logic              pending_q, primed_q;
  logic [CH_W-1:0]   ch_q;
  logic [DATA_W-1:0] raw_q [N_CH];
  logic [DATA_W-1:0] w_q [N_SMOOTH];
  logic [HC_W-1:0]   w6_q;

  logic [DATA_W-1:0]  freq_q, freq_scale_q;
  logic [DIV_BIT-1:0] hs0_q, si0_q, hs1_q, si1_q;
  logic [HC_W-1:0]    hc_q;
  logic               update_q, busy_q;

  logic [DATA_W-1:0]        raw_sel, w_sel, step, w_new;
  logic signed [DATA_W:0]   diff, shifted;
  logic [HC_W-1:0]          hc_new;

  // One filter step for the channel selected by ch_q; the +/-1 nudge guarantees convergence
  always_comb begin
    raw_sel = '0;
    w_sel   = '0;
    for (int i = 0; i < int'(N_CH); i++)
      if (ch_q == CH_W'(i)) raw_sel = raw_q[i];
    for (int i = 0; i < int'(N_SMOOTH); i++)
      if (ch_q == CH_W'(i)) w_sel = w_q[i];
    diff    = $signed({1'b0, raw_sel}) - $signed({1'b0, w_sel});
    shifted = diff >>> SMOOTH_SHIFT;
    if (shifted == '0 && diff != '0)
      step = diff[DATA_W] ? '1 : DATA_W'(1);
    else
      step = shifted[DATA_W-1:0];
    w_new  = w_sel + step;
    hc_new = (raw_sel[DATA_W-1:HC_W] != '0 || raw_sel[HC_W-1:0] > HC_MAX) ?
             HC_MAX : raw_sel[HC_W-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      sm_idle:          if (edge_q) state_d = sm_capture;
      sm_capture:       state_d = sm_filter;
      sm_filter:        if (ch_q == LAST_CH) state_d = sm_wait_boundary;
      sm_wait_boundary: if (i_Sample_Boundary) state_d = sm_commit;
      sm_commit:        state_d = (pending_q || edge_q) ? sm_capture : sm_idle;
      default:          state_d = sm_idle;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q      <= sm_idle;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      edge_q       <= 1'b0;
      pending_q    <= 1'b0;
      primed_q     <= 1'b0;
      ch_q         <= '0;
      for (int i = 0; i < int'(N_CH); i++) raw_q[i] <= '0;
      for (int i = 0; i < int'(N_SMOOTH); i++) w_q[i] <= (i == 0) ? FREQ_RESET : '0;
      w6_q         <= '0;
      freq_q       <= FREQ_RESET;
      hs0_q        <= '0;
      si0_q        <= '0;
      hs1_q        <= '0;
      si1_q        <= '0;
      freq_scale_q <= '0;
      hc_q         <= '0;
      update_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q  <= i_Data_Received;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      edge_q   <= sync2_q & ~sync3_q;
      state_q  <= state_d;
      busy_q   <= (state_d != sm_idle);
      update_q <= (state_d == sm_commit);

      if (edge_q && state_q != sm_idle) pending_q <= 1'b1;
      if (state_q == sm_commit && state_d == sm_capture) pending_q <= 1'b0;

      if (state_q == sm_capture) begin
        raw_q[0] <= i_Data0;
        raw_q[1] <= i_Data1;
        raw_q[2] <= i_Data2;
        raw_q[3] <= i_Data3;
        raw_q[4] <= i_Data4;
        raw_q[5] <= i_Data5;
        raw_q[6] <= i_Data6;
        ch_q     <= '0;
      end

      if (state_q == sm_filter) begin
        for (int i = 0; i < int'(N_SMOOTH); i++)
          if (ch_q == CH_W'(i)) w_q[i] <= primed_q ? w_new : raw_sel;
        if (ch_q == LAST_CH) begin
          w6_q     <= hc_new;
          primed_q <= 1'b1;
        end
        ch_q <= ch_q + CH_W'(1);
      end

      // Outputs move only on entry to the commit cycle, alongside o_Update
      if (state_d == sm_commit) begin
        freq_q       <= w_q[0];
        hs0_q        <= w_q[1][DIV_BIT-1:0];
        si0_q        <= w_q[2][DIV_BIT-1:0];
        hs1_q        <= w_q[3][DIV_BIT-1:0];
        si1_q        <= w_q[4][DIV_BIT-1:0];
        freq_scale_q <= w_q[5];
        hc_q         <= w6_q;
      end
    end
  end

  assign o_Frequency       = freq_q;
  assign o_Harmonic_Scale0 = hs0_q;
  assign o_Scale_Initial0  = si0_q;
  assign o_Harmonic_Scale1 = hs1_q;
  assign o_Scale_Initial1  = si1_q;
  assign o_Freq_Scale      = freq_scale_q;
  assign o_Harmonic_Count  = hc_q;
  assign o_Update          = update_q;
  assign o_Busy            = busy_q;

endmodule

// File: tb/tb_control_smoother.sv
// Randomised and directed bench for control_smoother against a frame-level model
// of the smoothing, clamping and commit rules.
module tb_control_smoother;

  localparam int unsigned DIV_BIT = 11;
  localparam int unsigned NH      = 100;
  localparam int unsigned SS      = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, dr, sb;
  logic [15:0]        din [7];
  logic [15:0]        o_freq, o_fscale;
  logic [DIV_BIT-1:0] o_hs0, o_si0, o_hs1, o_si1;
  logic [7:0]         o_hc;
  logic               o_upd, o_busy;

  control_smoother #(.DIV_BIT(DIV_BIT), .NO_OF_HARMONICS(NH), .SMOOTH_SHIFT(SS)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Data_Received(dr),
    .i_Data0(din[0]), .i_Data1(din[1]), .i_Data2(din[2]), .i_Data3(din[3]),
    .i_Data4(din[4]), .i_Data5(din[5]), .i_Data6(din[6]),
    .i_Sample_Boundary(sb),
    .o_Frequency(o_freq), .o_Harmonic_Scale0(o_hs0), .o_Scale_Initial0(o_si0),
    .o_Harmonic_Scale1(o_hs1), .o_Scale_Initial1(o_si1), .o_Freq_Scale(o_fscale),
    .o_Harmonic_Count(o_hc), .o_Update(o_upd), .o_Busy(o_busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int upd_cnt  = 0;

  always @(negedge clk) if (o_upd === 1'b1) upd_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: committed state after each frame
  int mw [6];
  int mh;
  bit primed;

  function automatic int floor_div(input int a, input int d);
    return (a >= 0) ? a / d : -((-a + d - 1) / d);
  endfunction

  task automatic model_reset();
    mw[0] = 90;
    for (int i = 1; i < 6; i++) mw[i] = 0;
    mh = 0;
    primed = 1'b0;
  endtask

  task automatic model_apply(input logic [15:0] f [7]);
    int diff, st;
    for (int c = 0; c < 6; c++) begin
      if (!primed) mw[c] = int'(f[c]);
      else begin
        diff = int'(f[c]) - mw[c];
        st   = floor_div(diff, 1 << SS);
        if (st == 0 && diff != 0) st = (diff > 0) ? 1 : -1;
        mw[c] = mw[c] + st;
      end
    end
    mh = (int'(f[6]) > int'(NH)) ? int'(NH) : int'(f[6]);
    primed = 1'b1;
  endtask

  task automatic check_outputs(input string tag);
    int m;
    m = 1 << DIV_BIT;
    check({tag, ".freq"},   32'(o_freq),   32'(mw[0]));
    check({tag, ".hs0"},    32'(o_hs0),    32'(mw[1] % m));
    check({tag, ".si0"},    32'(o_si0),    32'(mw[2] % m));
    check({tag, ".hs1"},    32'(o_hs1),    32'(mw[3] % m));
    check({tag, ".si1"},    32'(o_si1),    32'(mw[4] % m));
    check({tag, ".fscale"}, 32'(o_fscale), 32'(mw[5]));
    check({tag, ".hc"},     32'(o_hc),     32'(mh));
  endtask

  task automatic do_reset();
    rst = 1'b1; dr = 1'b0; sb = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_update(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (o_upd === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, ".upd_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic run_frame(input int bdelay, input string tag);
    int start;
    logic [15:0] f [7];
    start = upd_cnt;
    f = din;
    check({tag, ".idle"}, 32'(o_busy), 32'd0);
    dr = 1'b1;
    repeat (2) @(negedge clk);
    dr = 1'b0;
    repeat (14) @(negedge clk);
    check({tag, ".busy"}, 32'(o_busy), 32'd1);
    repeat (bdelay) @(negedge clk);
    sb = 1'b1;
    @(negedge clk);
    sb = 1'b0;
    wait_update(tag);
    model_apply(f);
    check_outputs(tag);
    repeat (3) @(negedge clk);
    check({tag, ".upd_once"}, 32'(upd_cnt - start), 32'd1);
    check({tag, ".upd_low"}, 32'(o_upd), 32'd0);
    check_outputs({tag, ".hold"});
  endtask

  task automatic set_frame(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c6);
    for (int i = 0; i < 7; i++) din[i] = 16'd0;
    din[0] = c0; din[1] = c1; din[6] = c6;
  endtask

  initial begin
    logic [15:0] fa [7];
    logic [15:0] fb [7];
    int start;
    set_frame(16'd0, 16'd0, 16'd0);
    do_reset();

    check("rst.busy", 32'(o_busy), 32'd0);
    check("rst.upd", 32'(o_upd), 32'd0);
    check_outputs("rst");

    // First frame loads unsmoothed, then a smoothed step toward 2000 and convergence
    set_frame(16'd1000, 16'd0, 16'd50);
    run_frame(0, "first");
    check("first.freq_abs", 32'(o_freq), 32'd1000);
    check("first.hc_abs", 32'(o_hc), 32'd50);
    set_frame(16'd2000, 16'd0, 16'd50);
    run_frame(2, "step");
    check("step.freq_abs", 32'(o_freq), 32'd1125);
    for (int k = 0; k < 60; k++) begin
      run_frame(k % 4, "conv");
      check("conv.no_over", 32'(o_freq > 16'd2000), 32'd0);
    end
    check("conv.final", 32'(o_freq), 32'd2000);

    // Small differences use the +/-1 rule; a drop to zero never wraps
    do_reset();
    set_frame(16'd1000, 16'd0, 16'd0);
    run_frame(0, "p1000");
    set_frame(16'd1004, 16'd0, 16'd0);
    for (int k = 0; k < 4; k++) begin
      run_frame(1, "inc");
      check("inc.abs", 32'(o_freq), 32'(1001 + k));
    end
    do_reset();
    set_frame(16'd5, 16'd0, 16'd0);
    run_frame(0, "p5");
    set_frame(16'd0, 16'd0, 16'd0);
    for (int k = 0; k < 6; k++) begin
      run_frame(0, "dec");
      check("dec.abs", 32'(o_freq), 32'((k < 5) ? 4 - k : 0));
    end

    // Harmonic clamp and scale truncation
    do_reset();
    set_frame(16'd0, 16'hFFFF, 16'h00FF);
    run_frame(0, "clamp1");
    check("clamp1.hc_abs", 32'(o_hc), 32'd100);
    check("clamp1.hs0_abs", 32'(o_hs0), 32'h7FF);
    set_frame(16'd0, 16'hFFFF, 16'h0100);
    run_frame(0, "clamp2");
    check("clamp2.hc_abs", 32'(o_hc), 32'd100);

    // Two edges during filtering collapse into one pending capture; early boundaries ignored
    for (int i = 0; i < 7; i++) begin fa[i] = 16'($urandom); fb[i] = 16'($urandom); end
    din = fa;
    start = upd_cnt;
    dr = 1'b1; @(negedge clk); @(negedge clk);
    dr = 1'b0; sb = 1'b1; @(negedge clk);
    sb = 1'b0; @(negedge clk); @(negedge clk);
    din = fb; dr = 1'b1; @(negedge clk);
    dr = 1'b0; @(negedge clk);
    dr = 1'b1; @(negedge clk);
    dr = 1'b0; @(negedge clk);
    sb = 1'b1; @(negedge clk);
    sb = 1'b0;
    repeat (10) @(negedge clk);
    check("pend.early_ign", 32'(upd_cnt - start), 32'd0);
    sb = 1'b1; @(negedge clk);
    sb = 1'b0;
    wait_update("pendA");
    model_apply(fa);
    check_outputs("pendA");
    repeat (14) @(negedge clk);
    check("pend.busy", 32'(o_busy), 32'd1);
    sb = 1'b1; @(negedge clk);
    sb = 1'b0;
    wait_update("pendB");
    model_apply(fb);
    check_outputs("pendB");
    repeat (10) @(negedge clk);
    check("pend.commits", 32'(upd_cnt - start), 32'd2);
    check("pend.idle", 32'(o_busy), 32'd0);

    // Reset mid-filter abandons the frame
    set_frame(16'd3000, 16'd7, 16'd9);
    dr = 1'b1; @(negedge clk); @(negedge clk);
    dr = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("mid.busy", 32'(o_busy), 32'd0);
    check("mid.freq", 32'(o_freq), 32'd90);
    start = upd_cnt;
    sb = 1'b1; @(negedge clk);
    sb = 1'b0;
    repeat (30) @(negedge clk);
    check("mid.no_upd", 32'(upd_cnt - start), 32'd0);
    check_outputs("mid");
    run_frame(0, "mid_new");

    // Randomised frames
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 6; i++) din[i] = 16'($urandom);
      din[6] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      run_frame(int'($urandom_range(0, 6)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/control_smoother.md
CONTROL_SMOOTHER -- requirements
Module: control_smoother

Interface
REQ-001 SHALL have parameter DIV_BIT, default 11: width of harmonic scale/initial outputs.
REQ-002 SHALL have parameter NO_OF_HARMONICS, default 100: upper clamp for harmonic count.
REQ-003 SHALL have parameter SMOOTH_SHIFT, default 3: IIR coefficient 1/2^SMOOTH_SHIFT.
REQ-004 SHALL have port i_Clock  in  1: single clock (48MHz main clock); all logic on rising edge.
REQ-005 SHALL have port i_Reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port i_Data_Received  in  1: frame-complete pulse from the ADC SPI receiver, asynchronous to i_Clock.
REQ-007 SHALL have ports i_Data0..i_Data6  in  16 each: raw ADC words; they are stable while i_Data_Received is high.
REQ-008 SHALL have port i_Sample_Boundary  in  1: one-cycle pulse from the top-level sequencer at the DAC send point.
REQ-009 SHALL have port o_Frequency  out  16: smoothed channel 0.
REQ-010 SHALL have ports o_Harmonic_Scale0/o_Scale_Initial0/o_Harmonic_Scale1/o_Scale_Initial1  out  DIV_BIT each: smoothed channels 1-4, low DIV_BIT bits.
REQ-011 SHALL have port o_Freq_Scale  out  16: smoothed channel 5.
REQ-012 SHALL have port o_Harmonic_Count  out  8: channel 6, unsmoothed, clamped.
REQ-013 SHALL have port o_Update  out  1: one-cycle pulse when outputs change.
REQ-014 SHALL have port o_Busy  out  1: high in any state other than sm_idle.

Function
REQ-015 SHALL synchronise i_Data_Received through two flops and detect rising edge on the synchronised signal; edge asserts exactly 2 cycles after the 2nd flop sees high.
REQ-016 SHALL use states sm_idle, sm_capture, sm_filter, sm_wait_boundary, sm_commit.
REQ-017 sm_idle -> sm_capture on edge; sm_capture latches all 7 i_DataN into raw registers in one cycle, clears channel counter, -> sm_filter.
REQ-018 sm_filter processes one channel per cycle, channels 0..6 in order (7 cycles), then -> sm_wait_boundary.
REQ-019 Channels 0-5: working value W <= W + (17-bit signed (raw - W)) >>> SMOOTH_SHIFT, arithmetic shift.
REQ-020 If raw != W and shifted step is 0, step SHALL be +1 or -1 toward raw (guaranteed convergence, no overshoot).
REQ-021 W SHALL be held 16-bit unsigned; no wrap: result always lies between old W and raw inclusive.
REQ-022 Channel 6: W6 <= min(raw[7:0], NO_OF_HARMONICS); raw[15:8] nonzero also clamps to NO_OF_HARMONICS.
REQ-023 First frame after reset (primed flag clear) SHALL load W = raw for channels 0-5 with no smoothing, then set primed.
REQ-024 sm_wait_boundary holds until i_Sample_Boundary; -> sm_commit.
REQ-025 sm_commit copies all W to outputs in one cycle, o_Update high that cycle only; outputs never change at any other time.
REQ-026 After sm_commit: -> sm_capture if pending flag set (clearing it), else -> sm_idle.
REQ-027 Edge detected in any state other than sm_idle SHALL set pending; multiple edges collapse into one pending capture.
REQ-028 i_Sample_Boundary outside sm_wait_boundary SHALL be ignored.
REQ-029 Edge and i_Sample_Boundary in the same cycle during sm_wait_boundary: commit proceeds, pending set.
REQ-030 Scale outputs SHALL be W[DIV_BIT-1:0] of channels 1-4 (truncation, no saturation).

Reset
REQ-031 Reset SHALL force sm_idle, clear pending, primed, sync flops, counter, o_Update=0, o_Busy=0.
REQ-032 Reset values: o_Frequency=16'd90, W0=90; all other outputs and W registers 0.
REQ-033 Reset asserted mid-filter or mid-wait SHALL abandon the frame; outputs return to reset values next cycle.

Verification
REQ-034 Reset, frame ch0=1000, ch6=50, boundary pulse -> o_Frequency=1000 (unsmoothed first frame), o_Harmonic_Count=50, o_Update one cycle.
REQ-035 Primed W0=1000, frame ch0=2000, boundary -> o_Frequency=1125; repeated frames converge to exactly 2000, never exceed.
REQ-036 W0=1000, raw=1004 -> steps 1001,1002,1003,1004 (±1 rule); raw=0 from 5 -> reaches 0, no underflow wrap.
REQ-037 Frame ch6=16'h00FF, then 16'h0100 -> o_Harmonic_Count=100 both; ch1=16'hFFFF primed first frame -> o_Harmonic_Scale0=11'h7FF.
REQ-038 Two edges during sm_filter, boundary pulses late -> exactly two commits, second using latest raw data; boundary before filter done ignored.
REQ-039 Reset pulse during sm_filter -> o_Busy=0, o_Frequency=90, no o_Update until new frame and boundary.
